// File: rtl/mat_add_job_arbiter.sv
// rtl/mat_add_job_arbiter.sv - round-robin job arbiter sequencing one shared complex matrix-add core
// Every output is a flop; the FSM next-state and the next output values are built combinationally.
module mat_add_job_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int mat_num_row = 2,
  parameter int TIMEOUT     = 1024,
  localparam int MAT_W      = 2 * 64 * mat_num_row * mat_num_row,
  localparam int ID_W       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*MAT_W-1:0]   req_mat_a,
  input  logic [NUM_REQ*MAT_W-1:0]   req_mat_b,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [ID_W-1:0]            resp_id,
  output logic [MAT_W-1:0]           resp_mat,
  output logic                       resp_err,
  output logic                       busy,
  output logic                       core_start,
  output logic                       core_valid,
  output logic [MAT_W-1:0]           core_mat_a,
  output logic [MAT_W-1:0]           core_mat_b,
  output logic                       core_output_read,
  input  logic [MAT_W-1:0]           core_mat_out,
  input  logic                       core_done
);

  localparam int WD_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t              state, next_state;
  logic [ID_W-1:0]     rr_ptr, rr_ptr_d;
  logic [ID_W-1:0]     sel_id;
  logic                sel_found;
  logic [WD_W-1:0]     wd_cnt, wd_cnt_d;
  logic                wd_expired;
  logic                handshake;

  logic [NUM_REQ-1:0]  grant_d, req_ack_d;
  logic                resp_valid_d, resp_err_d, busy_d;
  logic                core_start_d, core_output_read_d;
  logic [ID_W-1:0]     resp_id_d;
  logic [MAT_W-1:0]    resp_mat_d, core_mat_a_d, core_mat_b_d;

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));
  assign handshake  = resp_valid && resp_ready;
  assign core_valid = core_start;

  // First requester at or after rr_ptr, wrapping, so the last one served ends up lowest priority.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!sel_found && req[(int'(rr_ptr) + i) % NUM_REQ]) begin
        sel_found = 1'b1;
        sel_id    = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (sel_found) next_state = ISSUE;
      ISSUE:   if (core_done) next_state = CAPTURE;
               else if (wd_expired) next_state = RESP;
      CAPTURE: next_state = RESP;
      RESP:    if (handshake) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    grant_d            = grant;
    req_ack_d          = '0;
    resp_valid_d       = 1'b0;
    resp_id_d          = resp_id;
    resp_mat_d         = resp_mat;
    resp_err_d         = resp_err;
    busy_d             = (next_state != IDLE);
    core_start_d       = 1'b0;
    core_mat_a_d       = core_mat_a;
    core_mat_b_d       = core_mat_b;
    core_output_read_d = 1'b0;
    wd_cnt_d           = wd_cnt;
    rr_ptr_d           = rr_ptr;
    case (state)
      IDLE: begin
        if (sel_found) begin
          grant_d           = '0;
          grant_d[sel_id]   = 1'b1;
          req_ack_d[sel_id] = 1'b1;
          resp_id_d         = sel_id;
          resp_err_d        = 1'b0;
          core_mat_a_d      = req_mat_a[int'(sel_id)*MAT_W +: MAT_W];
          core_mat_b_d      = req_mat_b[int'(sel_id)*MAT_W +: MAT_W];
          wd_cnt_d          = '0;
        end
      end
      ISSUE: begin
        wd_cnt_d     = wd_cnt + 1'b1;
        core_start_d = (next_state == ISSUE);
        // Only the watchdog path jumps straight to RESP; done always goes through CAPTURE.
        if (next_state == RESP) begin
          resp_err_d = 1'b1;
          resp_mat_d = '0;
        end
      end
      CAPTURE: begin
        resp_mat_d         = core_mat_out;
        resp_err_d         = 1'b0;
        core_output_read_d = 1'b1;
      end
      RESP: begin
        if (handshake) begin
          grant_d  = '0;
          rr_ptr_d = (resp_id == ID_W'(NUM_REQ - 1)) ? '0 : resp_id + 1'b1;
        end else begin
          resp_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      wd_cnt           <= '0;
      grant            <= '0;
      req_ack          <= '0;
      resp_valid       <= 1'b0;
      resp_id          <= '0;
      resp_mat         <= '0;
      resp_err         <= 1'b0;
      busy             <= 1'b0;
      core_start       <= 1'b0;
      core_mat_a       <= '0;
      core_mat_b       <= '0;
      core_output_read <= 1'b0;
    end else begin
      state            <= next_state;
      rr_ptr           <= rr_ptr_d;
      wd_cnt           <= wd_cnt_d;
      grant            <= grant_d;
      req_ack          <= req_ack_d;
      resp_valid       <= resp_valid_d;
      resp_id          <= resp_id_d;
      resp_mat         <= resp_mat_d;
      resp_err         <= resp_err_d;
      busy             <= busy_d;
      core_start       <= core_start_d;
      core_mat_a       <= core_mat_a_d;
      core_mat_b       <= core_mat_b_d;
      core_output_read <= core_output_read_d;
    end
  end

endmodule
